// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the ECC scalar-multiplication controller.
//   ECC_W / ECC_NIB  : default field width and serial nibble width
//   ECC_STREAM_LEN   : number of nibbles in one result stream (x then y)
//   OP_DBL / OP_ADD  : point-unit command codes
//   IDLE..OUT        : controller state codes
package ecc_pkg;

    localparam int unsigned ECC_W          = 32;
    localparam int unsigned ECC_NIB        = 4;
    localparam int unsigned ECC_STREAM_LEN = 2 * ECC_W / ECC_NIB;

    localparam logic OP_DBL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t SCAN     = 3'd1;
    localparam state_t DBL      = 3'd2;
    localparam state_t DBL_WAIT = 3'd3;
    localparam state_t ADD      = 3'd4;
    localparam state_t ADD_WAIT = 3'd5;
    localparam state_t OUT      = 3'd6;

    // Nibble count of an (x,y) stream for a given coordinate width.
    function automatic int unsigned stream_len(input int unsigned w, input int unsigned nib);
        return 2 * w / nib;
    endfunction

endpackage

// File: rtl/ecc_nibble_ser.sv
// ecc_nibble_ser: parallel-load, MSB-first shift-out serializer.
//   clk, rst (async, active-low)
//   load  : capture din and start a stream of W/NIB nibbles
//   din   : W-bit word to stream
//   valid : high while nibbles are being presented
//   last  : high on the final nibble of the stream
//   dout  : current nibble (0 when not valid)
module ecc_nibble_ser #(
    parameter int unsigned W   = 64,
    parameter int unsigned NIB = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [W-1:0]   din,
    output logic           valid,
    output logic           last,
    output logic [NIB-1:0] dout
);

    localparam int unsigned LEN = W / NIB;
    localparam int unsigned CW  = $clog2(LEN + 1);

    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= din;
            cnt   <= CW'(LEN);
        end else if (cnt != '0) begin
            shreg <= shreg << NIB;
            cnt   <= cnt - CW'(1);
        end
    end

    assign valid = (cnt != '0);
    assign last  = (cnt == CW'(1));
    assign dout  = valid ? shreg[W-1 -: NIB] : '0;

endmodule

// File: rtl/ecc_scalar_ctrl.sv
// ecc_scalar_ctrl: left-to-right double-and-add sequencer for kP.
//   clk, rst (async, active-low)
//   start, k, px, py        : launch request and operands (taken in IDLE)
//   ready                   : high only in IDLE
//   pu_start, pu_op         : one-cycle command pulse and op (0=DBL, 1=ADD)
//   pu_x1/pu_y1, pu_x2/pu_y2: command operands R and P (held)
//   pu_done, pu_x, pu_y, pu_inf : point-unit completion and result
//   out_valid, kp, kp_inf   : nibble-serial result stream, x then y, MSB first
module ecc_scalar_ctrl
    import ecc_pkg::*;
#(
    parameter int unsigned W   = ECC_W,
    parameter int unsigned NIB = ECC_NIB
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   k,
    input  logic [W-1:0]   px,
    input  logic [W-1:0]   py,
    output logic           ready,
    output logic           pu_start,
    output logic           pu_op,
    output logic [W-1:0]   pu_x1,
    output logic [W-1:0]   pu_y1,
    output logic [W-1:0]   pu_x2,
    output logic [W-1:0]   pu_y2,
    input  logic           pu_done,
    input  logic [W-1:0]   pu_x,
    input  logic [W-1:0]   pu_y,
    input  logic           pu_inf,
    output logic           out_valid,
    output logic [NIB-1:0] kp,
    output logic           kp_inf
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    state_t         state, state_n;
    logic [W-1:0]   k_r, k_n;
    logic [IW-1:0]  idx, idx_n;
    logic [W-1:0]   px_r, py_r, px_n, py_n;
    logic [W-1:0]   rx, ry, rx_n, ry_n;
    logic           r_inf, rinf_n;
    logic           start_r, start_n;
    logic           op_r, op_n;
    logic           kp_inf_r;
    logic           eval_bit, next_bit;

    logic           ser_load, ser_valid, ser_last;
    logic [2*W-1:0] ser_din;
    logic [NIB-1:0] ser_dout;

    // k_r is kept left-aligned so the bit under evaluation is always k_r[W-1];
    // idx is that bit's position, so idx==0 means no lower bits remain.
    always_comb begin
        state_n  = state;
        k_n      = k_r;
        idx_n    = idx;
        px_n     = px_r;
        py_n     = py_r;
        rx_n     = rx;
        ry_n     = ry;
        rinf_n   = r_inf;
        start_n  = 1'b0;
        op_n     = op_r;
        eval_bit = 1'b0;
        next_bit = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    k_n     = k;
                    px_n    = px;
                    py_n    = py;
                    idx_n   = IW'(W - 1);
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (k_r == '0) begin
                    rinf_n  = 1'b1;
                    state_n = OUT;
                end else if (k_r[W-1]) begin
                    rx_n   = px_r;
                    ry_n   = py_r;
                    rinf_n = 1'b0;
                    next_bit = 1'b1;
                end else if (idx == '0) begin
                    rinf_n  = 1'b1;
                    state_n = OUT;
                end else begin
                    k_n   = k_r << 1;
                    idx_n = idx - IW'(1);
                end
            end
            DBL: begin
                // Doubling infinity is infinity: skip the unit.
                if (r_inf) begin
                    eval_bit = 1'b1;
                end else begin
                    start_n = 1'b1;
                    op_n    = OP_DBL;
                    state_n = DBL_WAIT;
                end
            end
            DBL_WAIT: begin
                if (pu_done) begin
                    rx_n     = pu_x;
                    ry_n     = pu_y;
                    rinf_n   = pu_inf;
                    eval_bit = 1'b1;
                end
            end
            ADD: begin
                // inf + P = P without the unit.
                if (r_inf) begin
                    rx_n     = px_r;
                    ry_n     = py_r;
                    rinf_n   = 1'b0;
                    next_bit = 1'b1;
                end else begin
                    start_n = 1'b1;
                    op_n    = OP_ADD;
                    state_n = ADD_WAIT;
                end
            end
            ADD_WAIT: begin
                if (pu_done) begin
                    rx_n     = pu_x;
                    ry_n     = pu_y;
                    rinf_n   = pu_inf;
                    next_bit = 1'b1;
                end
            end
            OUT: begin
                if (ser_last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (eval_bit) begin
            if (k_r[W-1]) begin
                state_n = ADD;
            end else begin
                next_bit = 1'b1;
            end
        end

        if (next_bit) begin
            if (idx != '0) begin
                state_n = DBL;
                k_n     = k_r << 1;
                idx_n   = idx - IW'(1);
            end else begin
                state_n = OUT;
            end
        end
    end

    // The stream is loaded from the next-state R so a result latched in the
    // same cycle as the OUT transition is the one streamed.
    assign ser_load = (state_n == OUT) && (state != OUT);
    assign ser_din  = rinf_n ? '0 : {rx_n, ry_n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            k_r      <= '0;
            idx      <= '0;
            px_r     <= '0;
            py_r     <= '0;
            rx       <= '0;
            ry       <= '0;
            r_inf    <= 1'b0;
            start_r  <= 1'b0;
            op_r     <= 1'b0;
            kp_inf_r <= 1'b0;
        end else begin
            state   <= state_n;
            k_r     <= k_n;
            idx     <= idx_n;
            px_r    <= px_n;
            py_r    <= py_n;
            rx      <= rx_n;
            ry      <= ry_n;
            r_inf   <= rinf_n;
            start_r <= start_n;
            op_r    <= op_n;
            if (ser_load) begin
                kp_inf_r <= rinf_n;
            end else if (ser_last) begin
                kp_inf_r <= 1'b0;
            end
        end
    end

    ecc_nibble_ser #(
        .W   (2 * W),
        .NIB (NIB)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .load  (ser_load),
        .din   (ser_din),
        .valid (ser_valid),
        .last  (ser_last),
        .dout  (ser_dout)
    );

    assign ready     = (state == IDLE);
    assign pu_start  = start_r;
    assign pu_op     = op_r;
    assign pu_x1     = rx;
    assign pu_y1     = ry;
    assign pu_x2     = px_r;
    assign pu_y2     = py_r;
    assign out_valid = ser_valid;
    assign kp        = ser_dout;
    assign kp_inf    = kp_inf_r;

endmodule

// File: tb/tb_ecc_scalar_ctrl.sv
// tb_ecc_scalar_ctrl: directed bench for ecc_scalar_ctrl with a mock point
// unit and a textbook double-and-add reference model.
module tb_ecc_scalar_ctrl;
    import ecc_pkg::*;

    localparam int W   = 32;
    localparam int NIB = 4;
    localparam int NN  = 2 * W / NIB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   k = '0, px = '0, py = '0;
    logic           ready, pu_start, pu_op, out_valid, kp_inf;
    logic [W-1:0]   pu_x1, pu_y1, pu_x2, pu_y2;
    logic           pu_done = 1'b0;
    logic [W-1:0]   pu_x = '0, pu_y = '0;
    logic           pu_inf = 1'b0;
    logic [NIB-1:0] kp;

    always #5 clk = ~clk;

    ecc_scalar_ctrl #(.W(W), .NIB(NIB)) dut (
        .clk(clk), .rst(rst), .start(start), .k(k), .px(px), .py(py),
        .ready(ready), .pu_start(pu_start), .pu_op(pu_op),
        .pu_x1(pu_x1), .pu_y1(pu_y1), .pu_x2(pu_x2), .pu_y2(pu_y2),
        .pu_done(pu_done), .pu_x(pu_x), .pu_y(pu_y), .pu_inf(pu_inf),
        .out_valid(out_valid), .kp(kp), .kp_inf(kp_inf)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Mock unit response: depends only on command number n within a run.
    function automatic logic [W-1:0] rsp_x(input int n, input logic op);
        return 32'h1000_0000 | (32'(n) << 8) | {31'd0, op};
    endfunction
    function automatic logic [W-1:0] rsp_y(input int n);
        return 32'h2000_0000 | 32'(n);
    endfunction

    typedef struct {
        logic         op;
        logic [W-1:0] x1, y1, x2, y2;
    } cmd_t;
    typedef struct {
        logic           inf;
        logic [NIB-1:0] nib;
    } nib_t;

    cmd_t cmd_q[$];
    nib_t exp_q[$];

    int epoch = 0, sync_idx = 0, run_base = 0, inf_at = -1, lat_fix = 3;

    // ---------------- mock point unit ----------------
    int   cmd_rd = 0, my_epoch = 0, u_cnt = 0, u_n = 0, unit_starts = 0;
    bit   u_busy = 1'b0;
    logic u_op = 1'b0;

    always @(negedge clk) begin
        if (epoch != my_epoch) begin
            my_epoch = epoch;
            cmd_rd   = sync_idx;
            u_busy   = 1'b0;
        end
        pu_done = 1'b0;
        if (u_busy) begin
            if (u_cnt == 0) begin
                u_busy  = 1'b0;
                pu_done = 1'b1;
                pu_x    = rsp_x(u_n, u_op);
                pu_y    = rsp_y(u_n);
                pu_inf  = (u_n == inf_at);
            end else begin
                u_cnt--;
            end
        end
        if (pu_start) begin
            unit_starts++;
            chk("one_outstanding", 64'(u_busy), 64'(0));
            u_n    = cmd_rd - run_base;
            u_op   = pu_op;
            u_busy = 1'b1;
            u_cnt  = (lat_fix > 0) ? lat_fix - 1 : int'($urandom_range(1, 10)) - 1;
            if (cmd_rd >= cmd_q.size()) begin
                chk("unexpected_cmd", 64'(pu_start), 64'(0));
            end else begin
                chk("cmd_op", 64'(pu_op), 64'(cmd_q[cmd_rd].op));
                chk("cmd_x1", 64'(pu_x1), 64'(cmd_q[cmd_rd].x1));
                chk("cmd_y1", 64'(pu_y1), 64'(cmd_q[cmd_rd].y1));
                if (cmd_q[cmd_rd].op == OP_ADD) begin
                    chk("cmd_x2", 64'(pu_x2), 64'(cmd_q[cmd_rd].x2));
                    chk("cmd_y2", 64'(pu_y2), 64'(cmd_q[cmd_rd].y2));
                end
                cmd_rd++;
            end
        end
    end

    // ---------------- stream comparator ----------------
    int           nib_rd = 0;
    logic [2*W-1:0] cap = '0;
    logic         last_inf = 1'b0;

    always @(negedge clk) begin
        if (rst && out_valid) begin
            chk("ready_low_in_stream", 64'(ready), 64'(0));
            if (nib_rd >= exp_q.size()) begin
                chk("unexpected_stream", 64'(out_valid), 64'(0));
            end else begin
                chk("kp", 64'(kp), 64'(exp_q[nib_rd].nib));
                chk("kp_inf", 64'(kp_inf), 64'(exp_q[nib_rd].inf));
                nib_rd++;
            end
            cap      = {cap[2*W-NIB-1:0], kp};
            last_inf = kp_inf;
        end
    end

    // ---------------- reference model ----------------
    // Plain left-to-right double-and-add starting from infinity.
    task automatic model(input logic [W-1:0] kk, input logic [W-1:0] xx, input logic [W-1:0] yy,
                         input bit with_stream, output int ncmd);
        logic [W-1:0]   rx = '0, ry = '0;
        logic [2*W-1:0] w;
        bit             rinf = 1'b1;
        int             n = 0;
        for (int b = W - 1; b >= 0; b--) begin
            if (!rinf) begin
                cmd_q.push_back(cmd_t'{OP_DBL, rx, ry, xx, yy});
                rx = rsp_x(n, OP_DBL); ry = rsp_y(n); rinf = (n == inf_at); n++;
            end
            if (kk[b]) begin
                if (rinf) begin
                    rx = xx; ry = yy; rinf = 1'b0;
                end else begin
                    cmd_q.push_back(cmd_t'{OP_ADD, rx, ry, xx, yy});
                    rx = rsp_x(n, OP_ADD); ry = rsp_y(n); rinf = (n == inf_at); n++;
                end
            end
        end
        ncmd = n;
        if (with_stream) begin
            w = rinf ? '0 : {rx, ry};
            for (int i = 0; i < NN; i++) begin
                exp_q.push_back(nib_t'{rinf, w[2*W-1 -: NIB]});
                w = w << NIB;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [W-1:0] res_x, res_y;
    int           run_s0, run_ncmd;

    task automatic prep(input logic [W-1:0] kk, input logic [W-1:0] xx, input logic [W-1:0] yy,
                        input int infa, input int lat, input bit with_stream);
        inf_at   = infa;
        lat_fix  = lat;
        run_s0   = unit_starts;
        run_base = cmd_q.size();
        sync_idx = cmd_q.size();
        epoch++;
        model(kk, xx, yy, with_stream, run_ncmd);
        tick();
        k = kk; px = xx; py = yy;
    endtask

    task automatic finish_run();
        int cyc = 0;
        while (!(nib_rd == exp_q.size() && ready) && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk("run_timeout", 64'(cyc < 3000), 64'(1));
        chk("cmd_count", 64'(unit_starts - run_s0), 64'(run_ncmd));
        chk("cmds_consumed", 64'(cmd_rd), 64'(cmd_q.size()));
        chk("idle_after", 64'({ready, out_valid}), 64'(2'b10));
        res_x = cap[2*W-1:W];
        res_y = cap[W-1:0];
    endtask

    task automatic run(input logic [W-1:0] kk, input logic [W-1:0] xx, input logic [W-1:0] yy,
                       input int infa, input int lat);
        prep(kk, xx, yy, infa, lat, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ready_falls", 64'(ready), 64'(0));
        k = '1; px = '0; py = '0;
        finish_run();
    endtask

    initial begin
        int cyc;

        #1 rst = 1'b0;
        #1;
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_pu_start", 64'(pu_start), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_kp", 64'(kp), 64'(0));
        chk("rst_kp_inf", 64'(kp_inf), 64'(0));
        tick(); tick();
        rst = 1'b1;
        tick();

        // k=1: R=P straight out of SCAN
        run(32'h1, 32'h5, 32'h1, -1, 3);
        chk("k1_x", 64'(res_x), 64'h5);
        chk("k1_y", 64'(res_y), 64'h1);
        chk("k1_inf", 64'(last_inf), 64'(0));
        chk("k1_cmds", 64'(unit_starts - run_s0), 64'(0));

        // k=0: infinity, all-zero stream
        run(32'h0, 32'h1234, 32'h5678, -1, 3);
        chk("k0_x", 64'(res_x), 64'h0);
        chk("k0_y", 64'(res_y), 64'h0);
        chk("k0_inf", 64'(last_inf), 64'(1));
        chk("k0_cmds", 64'(unit_starts - run_s0), 64'(0));

        // k=6: DBL, ADD, DBL; result is the third response
        run(32'h6, 32'hCAFE, 32'hBEEF, -1, 3);
        chk("k6_x", 64'(res_x), 64'h1000_0200);
        chk("k6_y", 64'(res_y), 64'h2000_0002);
        chk("k6_cmds", 64'(unit_starts - run_s0), 64'(3));

        // k=0x80000000: 31 doublings, random latency
        run(32'h8000_0000, 32'h11, 32'h22, -1, 0);
        chk("kmsb_x", 64'(res_x), 64'h1000_1E00);
        chk("kmsb_y", 64'(res_y), 64'h2000_001E);
        chk("kmsb_cmds", 64'(unit_starts - run_s0), 64'(31));

        // k=3 with the ADD returning infinity
        run(32'h3, 32'h33, 32'h44, 1, 3);
        chk("k3_x", 64'(res_x), 64'h0);
        chk("k3_inf", 64'(last_inf), 64'(1));
        chk("k3_cmds", 64'(unit_starts - run_s0), 64'(2));

        // k=7: infinite ADD, skipped DBL, then ADD gives P without the unit
        run(32'h7, 32'h77, 32'h88, 1, 2);
        chk("k7_x", 64'(res_x), 64'h77);
        chk("k7_y", 64'(res_y), 64'h88);
        chk("k7_inf", 64'(last_inf), 64'(0));
        chk("k7_cmds", 64'(unit_starts - run_s0), 64'(2));

        // Reset while waiting on a DBL; the late pu_done must be ignored
        prep(32'h6, 32'hAA, 32'hBB, -1, 8, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (unit_starts == run_s0 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("abort_cmd_seen", 64'(unit_starts - run_s0), 64'(1));
        rst = 1'b0;
        #1;
        chk("abort_ready", 64'(ready), 64'(1));
        chk("abort_pu_start", 64'(pu_start), 64'(0));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_kp", 64'(kp), 64'(0));
        chk("abort_kp_inf", 64'(kp_inf), 64'(0));
        chk("abort_pu_x1", 64'(pu_x1), 64'(0));
        tick();
        rst = 1'b1;
        cyc = 0;
        while (u_busy && cyc < 50) begin
            tick();
            chk("late_done_ready", 64'(ready), 64'(1));
            cyc++;
        end
        chk("late_done_delivered", 64'(u_busy), 64'(0));
        repeat (4) begin
            tick();
            chk("late_done_idle", 64'({ready, out_valid, pu_start}), 64'(3'b100));
        end
        chk("late_done_no_cmd", 64'(unit_starts - run_s0), 64'(1));

        // start held through SCAN and into OUT: exactly one job
        prep(32'h1, 32'hA, 32'hB, -1, 3, 1'b1);
        start = 1'b1;
        tick();
        chk("held_ready_falls", 64'(ready), 64'(0));
        k = '1;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            chk("held_busy", 64'(ready), 64'(0));
            cyc++;
        end
        chk("held_reached_out", 64'(out_valid), 64'(1));
        start = 1'b0;
        finish_run();
        chk("held_x", 64'(res_x), 64'hA);
        chk("held_y", 64'(res_y), 64'hB);
        repeat (4) begin
            tick();
            chk("held_no_relaunch", 64'({ready, out_valid}), 64'(2'b10));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_scalar_ctrl.md
Name: ecc_scalar_ctrl

Overview:
- Sequencer for ECC scalar multiplication kP using the left-to-right double-and-add method.
- Sits between the nibble-serial operand loader and the point-arithmetic unit.
- Accepts latched full-width k, Px and Py; issues DBL/ADD commands to the point unit; holds the running point R.
- Streams the final kP back out nibble-serially, matching the loader's input format.

Parameters:
- W, 32, field/scalar width in bits.
- NIB, 4, serial output width; W must be a multiple of NIB.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request; accepted only when ready=1.
- k  in  W  scalar.
- px  in  W  base point x.
- py  in  W  base point y.
- ready  out  1  high only in IDLE.
- pu_start  out  1  single-cycle command pulse to the point unit.
- pu_op  out  1  0=DBL, 1=ADD; held stable while a command is outstanding.
- pu_x1, pu_y1  out  W each  operand R (held).
- pu_x2, pu_y2  out  W each  operand P (held; don't-care for DBL).
- pu_done  in  1  single-cycle completion pulse.
- pu_x, pu_y  in  W each  result; valid with pu_done.
- pu_inf  in  1  result is the point at infinity; valid with pu_done.
- out_valid  out  1  high during the serial result stream.
- kp  out  NIB  result nibble.
- kp_inf  out  1  result is infinity; held high for the whole stream.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ready=1; pu_start=0; out_valid=0; kp=0; kp_inf=0; all internal registers 0.
- Reset asserted mid-operation aborts immediately. A pu_done arriving after reset is released while in IDLE is ignored.
- IDLE: on start=1, latch k, px and py; go to SCAN. ready falls on the next cycle. start while not IDLE is ignored.
- SCAN: one cycle per bit. Shift k left until its MSB is 1, decrementing bit index i from W-1.
  - If k==0, or i passes 0 with no set bit: R_inf=1, go to OUT.
  - On finding the MSB: R=P, R_inf=0. If i==0, go to OUT; otherwise go to DBL.
- DBL: consumes the next lower bit.
  - If R_inf=1: skip the unit entirely and evaluate the bit in the same cycle.
  - Otherwise: pulse pu_start with pu_op=0, wait in DBL_WAIT for pu_done, then set R=(pu_x,pu_y) and R_inf=pu_inf.
  - Then, if the bit is 1, go to ADD. Otherwise, go to DBL if bits remain, else OUT.
- ADD:
  - If R_inf=1: set R=P and R_inf=0 without using the unit (zero cycles of unit time).
  - Otherwise: pulse pu_start with pu_op=1, wait in ADD_WAIT for pu_done, then latch R and R_inf=pu_inf.
  - Then go to DBL if bits remain, else OUT.
- pu_start is high for exactly one cycle per command. At most one command is outstanding at any time. pu_done outside a WAIT state is ignored.
- OUT: 2·W/NIB cycles with out_valid=1.
  - x nibbles first, MSB first; then y nibbles, MSB first.
  - If R_inf=1: kp=0 for the whole stream and kp_inf=1.
  - After the last nibble, out_valid falls, go to IDLE, and ready=1 on the following cycle.
- Latency: no latency bound is imposed on pu_done.
- Widths: all coordinates are unsigned W bits; the controller performs no field arithmetic.

Decomposition:
- Shared package ecc_pkg: state enum (IDLE, SCAN, DBL, DBL_WAIT, ADD, ADD_WAIT, OUT), op codes OP_DBL=0 and OP_ADD=1, the W default, and the stream length constant 2·W/NIB.
- One natural sub-module: ecc_nibble_ser, a W-to-NIB shift-out serializer with a count-down counter, reused by the OUT phase.

Test Plan:
- k=1, P=(0x5,0x1): zero pu_start pulses; stream is x nibbles 0,0,0,0,0,0,0,5 then y nibbles 0,…,0,1; kp_inf=0.
- k=0: zero unit commands; 16-cycle stream of kp=0 with kp_inf=1; ready returns 1 afterwards.
- k=6 (binary 110), with a model unit returning fixed values and 3-cycle latency: command order is DBL, ADD, DBL. Final R equals the third response. pu_x1/pu_y1 match the prior response at each issue.
- k=0x80000000: 31 SCAN-free DBL commands, no ADD. Unit latency randomized 1–10 cycles; never two commands outstanding.
- Model unit returns pu_inf=1 on the ADD for k=3 (binary 11): result is inf, kp_inf=1, and the stream is all zeros. With k=7 (binary 111), after the infinite ADD the next DBL is skipped and the following ADD yields R=P with no pu_start pulse.
- Reset asserted in DBL_WAIT, and start held high during SCAN/OUT: outputs return to reset values asynchronously; the late pu_done is ignored; start during busy causes no relaunch.
